// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate decoder with one output register plus a skid entry; latency 1 cycle.
// Backpressure: in_ready is registered and drops only once the skid entry fills, so stalls never drop data.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter int SHAMT_EN = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       imm_type,
  output logic             illegal,
  output logic [TAG_W-1:0] tag_out,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t             w_dec;
  ent_t             r_main;
  ent_t             r_skid;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       w_op;
  logic [2:0]       w_f3;
  logic             w_accept;
  logic             w_deliver;

  assign w_op = instr_in[6:0];
  assign w_f3 = instr_in[14:12];

  always_comb begin
    w_dec     = '0;
    w_dec.tag = tag_in;
    case (w_op)
      7'b0000011, 7'b1100111: begin
        w_dec.typ = T_I;
        w_dec.imm = XLEN'($signed(instr_in[31:20]));
      end
      7'b0010011: begin
        if (SHAMT_EN != 0 && (w_f3 == 3'b001 || w_f3 == 3'b101)) begin
          w_dec.typ = T_SHAMT;
          w_dec.imm = (XLEN == 64) ? XLEN'(instr_in[25:20]) : XLEN'(instr_in[24:20]);
        end else begin
          w_dec.typ = T_I;
          w_dec.imm = XLEN'($signed(instr_in[31:20]));
        end
      end
      7'b0100011: begin
        w_dec.typ = T_S;
        w_dec.imm = XLEN'($signed({instr_in[31:25], instr_in[11:7]}));
      end
      7'b1100011: begin
        w_dec.typ = T_B;
        w_dec.imm = XLEN'($signed({instr_in[31], instr_in[7], instr_in[30:25],
                                   instr_in[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        w_dec.typ = T_U;
        w_dec.imm = XLEN'($signed({instr_in[31:12], 12'b0}));
      end
      7'b1101111: begin
        w_dec.typ = T_J;
        w_dec.imm = XLEN'($signed({instr_in[31], instr_in[19:12], instr_in[20],
                                   instr_in[30:21], 1'b0}));
      end
      7'b0110011, 7'b0001111, 7'b1110011: w_dec.typ = T_NONE;
      default:                            w_dec.ill = 1'b1;
    endcase
  end

  assign w_accept  = in_valid & ~r_skid_vld;
  assign w_deliver = r_main_vld & out_ready;

  // Invariant: the skid entry is only ever occupied while the main entry is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_deliver && r_main.ill && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
      if (flush) begin
        r_main_vld <= 1'b0;
        r_skid_vld <= 1'b0;
      end else if (w_deliver) begin
        if (r_skid_vld) begin
          r_main     <= r_skid;
          r_skid_vld <= 1'b0;
        end else if (w_accept) begin
          r_main <= w_dec;
        end else begin
          r_main_vld <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_main_vld) begin
          r_main     <= w_dec;
          r_main_vld <= 1'b1;
        end else begin
          r_skid     <= w_dec;
          r_skid_vld <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = ~r_skid_vld;
  assign out_valid = r_main_vld;
  assign imm_out   = r_main.imm;
  assign imm_type  = r_main.typ;
  assign illegal   = r_main.ill;
  assign tag_out   = r_main.tag;
  assign ill_cnt   = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit default instance and a 64-bit instance with a 2-bit counter.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;

  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instr_in, tag_in, imm_out, tag_out;
  logic [2:0]  imm_type;
  logic [15:0] ill_cnt;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, illegal2;
  logic [31:0] instr_in2;
  logic [7:0]  tag_in2, tag_out2;
  logic [63:0] imm_out2;
  logic [2:0]  imm_type2;
  logic [1:0]  ill_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out), .imm_type(imm_type),
    .illegal(illegal), .tag_out(tag_out), .ill_cnt(ill_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SHAMT_EN(1), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid2), .in_ready(in_ready2), .instr_in(instr_in2), .tag_in(tag_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .imm_out(imm_out2), .imm_type(imm_type2),
    .illegal(illegal2), .tag_out(tag_out2), .ill_cnt(ill_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; instr_in = 32'hFFF00093; tag_in = 32'h55; out_ready = 1'b0;
    in_valid2 = 1'b1; instr_in2 = 32'h0; tag_in2 = 8'h55; out_ready2 = 1'b0;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (imm_out !== 32'h0) begin n_fail++; $display("FAIL reset_imm got %h want 0", imm_out); end
    n_checks++; if (imm_type !== 3'd0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_type_ill got %0d/%b want 0/0", imm_type, illegal); end
    n_checks++; if (tag_out !== 32'h0 || ill_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_tag_cnt got %h/%h want 0/0", tag_out, ill_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid2 !== 1'b0 || ill_cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset64 got vld %b cnt %0d want 0/0", out_valid2, ill_cnt2); end
    in_valid = 1'b0; in_valid2 = 1'b0;
    rst = 1'b0;
    step();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset got rdy %b vld %b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_decode();
    logic [31:0] v_instr [6];
    logic [31:0] v_imm   [6];
    logic [2:0]  v_type  [6];
    v_instr = '{32'hFFF00093, 32'hFE112E23, 32'hFF9FF06F, 32'h123452B7, 32'h4030D093, 32'h00000033};
    v_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000003, 32'h00000000};
    v_type  = '{3'd1, 3'd2, 3'd5, 3'd4, 3'd6, 3'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; instr_in = v_instr[i]; tag_in = 32'h100 + i;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || imm_out !== v_imm[i] || imm_type !== v_type[i] ||
          illegal !== 1'b0 || tag_out !== 32'h100 + i) begin
        n_fail++;
        $display("FAIL decode_%0d got vld %b imm %h type %0d ill %b tag %h want 1 %h %0d 0 %h",
                 i, out_valid, imm_out, imm_type, illegal, tag_out, v_imm[i], v_type[i], 32'h100 + i);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL decode_drain got vld %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'hFFF00093;
    tag_in = 32'd1; step();
    n_checks++; if (out_valid !== 1'b1 || tag_out !== 32'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_c1 got vld %b tag %0d rdy %b want 1 1 1", out_valid, tag_out, in_ready); end
    tag_in = 32'd2; step();
    n_checks++; if (in_ready !== 1'b0 || tag_out !== 32'd1) begin n_fail++; $display("FAIL stall_c2 got rdy %b tag %0d want 0 1", in_ready, tag_out); end
    tag_in = 32'd3; step();
    n_checks++; if (in_ready !== 1'b0 || tag_out !== 32'd1 || imm_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL stall_c3 got rdy %b tag %0d imm %h want 0 1 ffffffff", in_ready, tag_out, imm_out); end
    out_ready = 1'b1; step();
    n_checks++; if (out_valid !== 1'b1 || tag_out !== 32'd2 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rel1 got vld %b tag %0d rdy %b want 1 2 1", out_valid, tag_out, in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || tag_out !== 32'd3) begin n_fail++; $display("FAIL stall_rel2 got vld %b tag %0d want 1 3", out_valid, tag_out); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got vld %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'h0; tag_in = 32'h40;
    step();
    n_checks++; if (illegal !== 1'b1 || imm_out !== 32'h0 || imm_type !== 3'd0) begin n_fail++; $display("FAIL illegal_out got ill %b imm %h type %0d want 1 0 0", illegal, imm_out, imm_type); end
    step();
    n_checks++; if (ill_cnt !== 16'd1) begin n_fail++; $display("FAIL illegal_cnt1 got %0d want 1", ill_cnt); end
    step();
    in_valid = 1'b0;
    step();
    n_checks++; if (ill_cnt !== 16'd3 || out_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_cnt3 got %0d vld %b want 3 0", ill_cnt, out_valid); end

    out_ready2 = 1'b1; in_valid2 = 1'b1; instr_in2 = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 3) begin
        n_checks++; if (ill_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_at3 got %0d want 3", ill_cnt2); end
      end
    end
    in_valid2 = 1'b0;
    step();
    n_checks++; if (ill_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_hold got %0d want 3", ill_cnt2); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'hFFF00093;
    tag_in = 32'h10; step();
    tag_in = 32'h11; step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_fill got rdy %b want 0", in_ready); end
    flush = 1'b1; tag_in = 32'h12; step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clear got vld %b rdy %b want 0 1", out_valid, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak_%0d got vld %b tag %h want 0", i, out_valid, tag_out); end
    end
    out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'h0; tag_in = 32'h20; step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1; step();
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || ill_cnt !== 16'd4) begin n_fail++; $display("FAIL flush_deliver got vld %b cnt %0d want 0 4", out_valid, ill_cnt); end
  endtask

  task automatic test_xlen64();
    logic [31:0] v_instr [3];
    logic [63:0] v_imm   [3];
    logic [2:0]  v_type  [3];
    v_instr = '{32'hFE000FE3, 32'h800002B7, 32'h02109093};
    v_imm   = '{64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFF80000000, 64'h0000000000000021};
    v_type  = '{3'd3, 3'd4, 3'd6};
    out_ready2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid2 = 1'b1; instr_in2 = v_instr[i]; tag_in2 = 8'hA0 + 8'(i);
      step();
      n_checks++;
      if (out_valid2 !== 1'b1 || imm_out2 !== v_imm[i] || imm_type2 !== v_type[i] ||
          illegal2 !== 1'b0 || tag_out2 !== 8'hA0 + 8'(i)) begin
        n_fail++;
        $display("FAIL x64_%0d got vld %b imm %h type %0d ill %b tag %h want 1 %h %0d 0 %h",
                 i, out_valid2, imm_out2, imm_type2, illegal2, tag_out2, v_imm[i], v_type[i], 8'hA0 + 8'(i));
      end
    end
    in_valid2 = 1'b0;
    step();
  endtask

  task automatic test_rst_mid_stall();
    out_ready2 = 1'b0; in_valid2 = 1'b1; instr_in2 = 32'h0; tag_in2 = 8'h77;
    step(); step();
    in_valid2 = 1'b0;
    n_checks++; if (in_ready2 !== 1'b0 || ill_cnt2 !== 2'd3) begin n_fail++; $display("FAIL rst_pre got rdy %b cnt %0d want 0 3", in_ready2, ill_cnt2); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid2 !== 1'b0 || ill_cnt2 !== 2'd0 || in_ready2 !== 1'b1) begin n_fail++; $display("FAIL rst_async got vld %b cnt %0d rdy %b want 0 0 1", out_valid2, ill_cnt2, in_ready2); end
    @(posedge clk); #1 rst = 1'b0;
    out_ready2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL rst_leak_%0d got vld %b want 0", i, out_valid2); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stall();
    test_illegal();
    test_flush();
    test_xlen64();
    test_rst_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
